// File: rtl/mips_multicycle_controller.sv
// rtl/mips_multicycle_controller.sv - multi-cycle MIPS control FSM with memory wait-state watchdog
module mips_multicycle_controller #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] function_code,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] select_bits_ALU,
  output logic       shift,
  output logic       sltu,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] pc_source,
  output logic       pc_en,
  output logic       instr_done,
  output logic       illegal_instr,
  output logic       mem_timeout,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_ILLEGAL   = 4'd12,
    S_RESET     = 4'd13
  } state_t;

  localparam int CW = $clog2(WAIT_LIMIT + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_cnt;
  logic            mem_state, timeout_now;
  logic            pc_write, pc_write_cond, branch_ne;
  logic            r_legal, r_sltu;
  logic [2:0]      r_sel;

  assign mem_state   = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
  // Abort on the WAIT_LIMIT-th consecutive cycle without mem_ready; a late ready still completes.
  assign timeout_now = mem_state && !mem_ready && (wait_cnt == CW'(WAIT_LIMIT - 1));
  assign branch_ne   = (opcode == 6'b000101);
  assign shift       = select_bits_ALU[2] & select_bits_ALU[1];
  assign pc_en       = pc_write | (pc_write_cond & (zero ^ branch_ne));
  assign state       = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_RESET;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      if (timeout_now)
        mem_timeout <= 1'b1;
      if (mem_state && !mem_ready && !timeout_now)
        wait_cnt <= wait_cnt + CW'(1);
      else
        wait_cnt <= '0;
    end
  end

  always_comb begin
    r_legal = 1'b1;
    r_sel   = 3'b000;
    r_sltu  = 1'b0;
    case (function_code)
      6'b100000, 6'b100001: r_sel = 3'b000;
      6'b100010, 6'b100011: r_sel = 3'b001;
      6'b100100:            r_sel = 3'b010;
      6'b100101:            r_sel = 3'b011;
      6'b100111:            r_sel = 3'b100;
      6'b101011: begin
        r_sel  = 3'b101;
        r_sltu = 1'b1;
      end
      6'b000000:            r_sel = 3'b110;
      6'b000010:            r_sel = 3'b111;
      default:              r_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d         = S_FETCH;
    select_bits_ALU = 3'b000;
    sltu            = 1'b0;
    alu_src_a       = 1'b0;
    alu_src_b       = 2'b00;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    i_or_d          = 1'b0;
    ir_write        = 1'b0;
    reg_write       = 1'b0;
    reg_dst         = 1'b0;
    mem_to_reg      = 1'b0;
    pc_source       = 2'b00;
    pc_write        = 1'b0;
    pc_write_cond   = 1'b0;
    instr_done      = 1'b0;
    illegal_instr   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready)        state_d = S_DECODE;
        else if (timeout_now) state_d = S_ILLEGAL;
        else                  state_d = S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          6'b000000:            state_d = S_R_EXEC;
          6'b100011, 6'b101011: state_d = S_MEM_ADDR;
          6'b000100, 6'b000101: state_d = S_BRANCH;
          6'b001000:            state_d = S_I_EXEC;
          6'b000010:            state_d = S_JUMP;
          default:              state_d = S_ILLEGAL;
        endcase
      end
      S_R_EXEC: begin
        alu_src_a       = 1'b1;
        select_bits_ALU = r_sel;
        sltu            = r_sltu;
        state_d         = r_legal ? S_R_WB : S_ILLEGAL;
      end
      S_R_WB: begin
        alu_src_a       = 1'b1;
        select_bits_ALU = r_sel;
        sltu            = r_sltu;
        reg_write       = 1'b1;
        reg_dst         = 1'b1;
        instr_done      = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == 6'b101011) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready)        state_d = S_MEM_WB;
        else if (timeout_now) state_d = S_ILLEGAL;
        else                  state_d = S_MEM_READ;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        if (mem_ready)        state_d = S_FETCH;
        else if (timeout_now) state_d = S_ILLEGAL;
        else                  state_d = S_MEM_WRITE;
      end
      S_BRANCH: begin
        alu_src_a       = 1'b1;
        select_bits_ALU = 3'b001;
        pc_source       = 2'b01;
        pc_write_cond   = 1'b1;
        instr_done      = 1'b1;
      end
      S_JUMP: begin
        pc_source  = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_ILLEGAL: illegal_instr = 1'b1;
      default:   state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb/tb_mips_multicycle_controller.sv - randomized instruction-level bench for mips_multicycle_controller
module tb_mips_multicycle_controller;

  localparam int WL = 15;

  typedef struct packed {
    logic [2:0] alu;
    logic       shift, sltu, src_a;
    logic [1:0] src_b;
    logic       mrd, mwr, iod, irw, rw, rdst, m2r;
    logic [1:0] psrc;
    logic       pc_en, done, ill, tmo;
    logic [3:0] st;
  } ctl_t;

  typedef struct {
    ctl_t c;
    logic mr;
  } step_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, function_code;
  logic       zero, mem_ready;
  logic [2:0] select_bits_ALU;
  logic       shift, sltu, alu_src_a;
  logic [1:0] alu_src_b;
  logic       mem_read, mem_write, i_or_d, ir_write;
  logic       reg_write, reg_dst, mem_to_reg;
  logic [1:0] pc_source;
  logic       pc_en, instr_done, illegal_instr, mem_timeout;
  logic [3:0] state;

  mips_multicycle_controller #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .function_code(function_code),
    .zero(zero), .mem_ready(mem_ready), .select_bits_ALU(select_bits_ALU),
    .shift(shift), .sltu(sltu), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .pc_source(pc_source), .pc_en(pc_en), .instr_done(instr_done),
    .illegal_instr(illegal_instr), .mem_timeout(mem_timeout), .state(state)
  );

  always #5 clk = ~clk;

  ctl_t obs;
  assign obs = {select_bits_ALU, shift, sltu, alu_src_a, alu_src_b, mem_read, mem_write,
                i_or_d, ir_write, reg_write, reg_dst, mem_to_reg, pc_source, pc_en,
                instr_done, illegal_instr, mem_timeout, state};

  step_t q[$];
  logic  tmo_m;
  int    checks = 0;
  int    failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ctl_t blank(input logic [3:0] st);
    ctl_t c = '0;
    c.st = st;
    return c;
  endfunction

  task automatic push(input ctl_t c, input logic mr);
    step_t s;
    c.tmo = tmo_m;
    s.c = c;
    s.mr = mr;
    q.push_back(s);
  endtask

  // Queue the stall cycles of a memory state; a stall run of WL cycles ends in an abort.
  task automatic mem_wait(input ctl_t c, input int waits, output bit aborted);
    int n;
    ctl_t ic;
    n = (waits >= WL) ? WL : waits;
    for (int k = 0; k < n; k++) push(c, 1'b0);
    aborted = (waits >= WL);
    if (aborted) begin
      tmo_m = 1'b1;
      ic = blank(4'd12);
      ic.ill = 1'b1;
      push(ic, 1'($urandom));
    end
  endtask

  task automatic r_table(input logic [5:0] f, output bit legal, output logic [2:0] sel,
                         output logic sh, output logic su);
    legal = 1; sh = 0; su = 0; sel = 3'd0;
    case (f)
      6'h20, 6'h21: sel = 3'd0;
      6'h22, 6'h23: sel = 3'd1;
      6'h24: sel = 3'd2;
      6'h25: sel = 3'd3;
      6'h27: sel = 3'd4;
      6'h2b: begin sel = 3'd5; su = 1; end
      6'h00: begin sel = 3'd6; sh = 1; end
      6'h02: begin sel = 3'd7; sh = 1; end
      default: legal = 0;
    endcase
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fw, input int mw);
    ctl_t c;
    bit ab, legal;
    logic [2:0] sel;
    logic sh, su;
    q.delete();
    c = blank(4'd0); c.mrd = 1; c.src_b = 2'b01;
    mem_wait(c, fw, ab);
    if (ab) return;
    c.irw = 1; c.pc_en = 1;
    push(c, 1'b1);
    c = blank(4'd1); c.src_b = 2'b11;
    push(c, 1'($urandom));
    case (op)
      6'h00: begin
        r_table(fn, legal, sel, sh, su);
        c = blank(4'd6); c.src_a = 1; c.alu = sel; c.shift = sh; c.sltu = su;
        push(c, 1'($urandom));
        if (!legal) begin
          c = blank(4'd12); c.ill = 1; push(c, 1'($urandom));
        end else begin
          c.st = 4'd7; c.rw = 1; c.rdst = 1; c.done = 1;
          push(c, 1'($urandom));
        end
      end
      6'h23, 6'h2b: begin
        c = blank(4'd2); c.src_a = 1; c.src_b = 2'b10;
        push(c, 1'($urandom));
        if (op == 6'h23) begin
          c = blank(4'd3); c.mrd = 1; c.iod = 1;
          mem_wait(c, mw, ab);
          if (!ab) begin
            push(c, 1'b1);
            c = blank(4'd4); c.rw = 1; c.m2r = 1; c.done = 1;
            push(c, 1'($urandom));
          end
        end else begin
          c = blank(4'd5); c.mwr = 1; c.iod = 1;
          mem_wait(c, mw, ab);
          if (!ab) begin
            c.done = 1;
            push(c, 1'b1);
          end
        end
      end
      6'h04, 6'h05: begin
        c = blank(4'd8); c.src_a = 1; c.alu = 3'd1; c.psrc = 2'b01; c.done = 1;
        c.pc_en = (op == 6'h04) ? z : !z;
        push(c, 1'($urandom));
      end
      6'h02: begin
        c = blank(4'd9); c.psrc = 2'b10; c.pc_en = 1; c.done = 1;
        push(c, 1'($urandom));
      end
      6'h08: begin
        c = blank(4'd10); c.src_a = 1; c.src_b = 2'b10;
        push(c, 1'($urandom));
        c = blank(4'd11); c.rw = 1; c.done = 1;
        push(c, 1'($urandom));
      end
      default: begin
        c = blank(4'd12); c.ill = 1;
        push(c, 1'($urandom));
      end
    endcase
  endtask

  // Caller is at a falling edge with the DUT in FETCH.
  task automatic run(input string name, input int nsteps);
    int n;
    n = (nsteps < 0 || nsteps > q.size()) ? q.size() : nsteps;
    for (int i = 0; i < n; i++) begin
      mem_ready = q[i].mr;
      #1;
      check($sformatf("%s[%0d]", name, i), 32'(obs), 32'(q[i].c));
      @(negedge clk);
    end
  endtask

  task automatic do_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input int fw, input int mw);
    opcode = op;
    function_code = fn;
    zero = z;
    build(op, fn, z, fw, mw);
    run(name, -1);
  endtask

  logic [5:0] r_functs [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2b, 6'h00, 6'h02};
  logic [5:0] ops [8] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h02, 6'h3f};

  function automatic int rand_wait();
    int r;
    r = $urandom_range(0, 39);
    if (r == 0) return WL - 1;
    if (r == 1) return WL;
    if (r < 12) return $urandom_range(1, 4);
    return 0;
  endfunction

  initial begin
    logic [5:0] op, fn;
    reset = 1'b1; opcode = '0; function_code = '0; zero = 0; mem_ready = 0; tmo_m = 0;
    #1;
    check("reset_state", 32'(obs), 32'(blank(4'd13)));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) do_instr($sformatf("rtype%0d", i), 6'h00, r_functs[i], 1'($urandom), 0, 0);
    do_instr("addi", 6'h08, 6'h00, 0, 0, 0);
    do_instr("lw_wait3", 6'h23, 6'h00, 0, 0, 3);
    do_instr("sw", 6'h2b, 6'h00, 0, 0, 0);
    do_instr("sw_wait2", 6'h2b, 6'h00, 1, 1, 2);
    do_instr("beq_z1", 6'h04, 6'h00, 1, 0, 0);
    do_instr("beq_z0", 6'h04, 6'h00, 0, 0, 0);
    do_instr("bne_z1", 6'h05, 6'h00, 1, 0, 0);
    do_instr("bne_z0", 6'h05, 6'h00, 0, 0, 0);
    do_instr("jump", 6'h02, 6'h00, 0, 0, 0);
    do_instr("ill_op", 6'h3f, 6'h00, 0, 0, 0);
    do_instr("ill_funct", 6'h00, 6'h08, 0, 0, 0);
    do_instr("fetch_limit_ok", 6'h08, 6'h00, 0, WL - 1, 0);
    do_instr("lw_limit_ok", 6'h23, 6'h00, 0, 0, WL - 1);
    do_instr("fetch_timeout", 6'h00, 6'h20, 0, WL, 0);
    do_instr("after_timeout", 6'h02, 6'h00, 0, 0, 0);
    do_instr("lw_timeout", 6'h23, 6'h00, 0, 0, WL);
    do_instr("sw_timeout", 6'h2b, 6'h00, 0, 2, WL);

    for (int n = 0; n < 150; n++) begin
      op = ops[$urandom_range(0, 7)];
      if (op == 6'h3f) op = 6'($urandom);
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : r_functs[$urandom_range(0, 7)];
      do_instr($sformatf("rnd%0d", n), op, fn, 1'($urandom), rand_wait(), rand_wait());
    end

    opcode = 6'h23; zero = 0;
    build(6'h23, 6'h00, 0, 0, 5);
    run("lw_pre_reset", 4);
    mem_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    tmo_m = 1'b0;
    check("async_reset", 32'(obs), 32'(blank(4'd13)));
    @(negedge clk);
    check("reset_held", 32'(obs), 32'(blank(4'd13)));
    reset = 1'b0;
    #1;
    check("reset_release", 32'(obs), 32'(blank(4'd13)));
    @(negedge clk);
    do_instr("post_reset_r", 6'h00, 6'h25, 0, 0, 0);
    do_instr("post_reset_lw", 6'h23, 6'h00, 0, 0, 0);

    mem_ready = 1'b0;
    #1;
    check("final_fetch", 32'(state), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
